// File: rtl/alu_pkg.sv
// Opcode and skid-buffer state encodings shared by the ALU result stage.
package alu_pkg;

    localparam int unsigned OP_ADD = 0;
    localparam int unsigned OP_SUB = 1;
    localparam int unsigned OP_AND = 2;
    localparam int unsigned OP_OR  = 3;
    localparam int unsigned OP_SLL = 4;
    localparam int unsigned OP_SRA = 5;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_result_mux.sv
// Combinational opcode select of precomputed ALU results plus overflow/ne/lt/illegal flags.
// No latency, no flow control; ne/lt are derived from the subtractor for every opcode.
module alu_result_mux
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int OPCODE_WIDTH = 5
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [DATA_WIDTH-1:0]   res_add,
    input  logic [DATA_WIDTH-1:0]   res_sub,
    input  logic                    ovf_add,
    input  logic                    ovf_sub,
    input  logic [DATA_WIDTH-1:0]   res_and,
    input  logic [DATA_WIDTH-1:0]   res_or,
    input  logic [DATA_WIDTH-1:0]   res_sll,
    input  logic [DATA_WIDTH-1:0]   res_sra,
    output logic [DATA_WIDTH-1:0]   result,
    output logic                    overflow,
    output logic                    ne,
    output logic                    lt,
    output logic                    illegal
);

    always_comb begin
        result   = '0;
        overflow = 1'b0;
        illegal  = 1'b0;
        case (opcode)
            OPCODE_WIDTH'(OP_ADD): begin result = res_add; overflow = ovf_add; end
            OPCODE_WIDTH'(OP_SUB): begin result = res_sub; overflow = ovf_sub; end
            OPCODE_WIDTH'(OP_AND): result = res_and;
            OPCODE_WIDTH'(OP_OR):  result = res_or;
            OPCODE_WIDTH'(OP_SLL): result = res_sll;
            OPCODE_WIDTH'(OP_SRA): result = res_sra;
            default:               illegal = 1'b1;
        endcase
    end

    // Signed less-than: sign of A-B corrected by signed overflow.
    assign ne = |res_sub;
    assign lt = res_sub[DATA_WIDTH-1] ^ ovf_sub;

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: selects result/flags by opcode, presents them through a 2-entry skid buffer.
// Latency 1 cycle when empty, 1 op/cycle throughput; in_ready is a flop, low only when both entries are full.
// Optional ALU_RES_ZERO_FLAG_EN adds out_zero (result == 0) stored with each entry.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int OPCODE_WIDTH = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPCODE_WIDTH-1:0] in_opcode,
    input  logic [DATA_WIDTH-1:0]   in_res_add,
    input  logic [DATA_WIDTH-1:0]   in_res_sub,
    input  logic                    in_ovf_add,
    input  logic                    in_ovf_sub,
    input  logic [DATA_WIDTH-1:0]   in_res_and,
    input  logic [DATA_WIDTH-1:0]   in_res_or,
    input  logic [DATA_WIDTH-1:0]   in_res_sll,
    input  logic [DATA_WIDTH-1:0]   in_res_sra,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   out_result,
    output logic                    out_overflow,
    output logic                    out_ne,
    output logic                    out_lt,
`ifdef ALU_RES_ZERO_FLAG_EN
    output logic                    out_zero,
`endif
    output logic                    out_illegal
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic                  overflow;
        logic                  ne;
        logic                  lt;
        logic                  illegal;
`ifdef ALU_RES_ZERO_FLAG_EN
        logic                  zero;
`endif
    } entry_t;

    entry_t new_entry, main_q, skid_q;
    state_t state, state_next;
    logic   take_in, load_main, load_skid, move_skid;

    alu_result_mux #(
        .DATA_WIDTH   (DATA_WIDTH),
        .OPCODE_WIDTH (OPCODE_WIDTH)
    ) u_mux (
        .opcode   (in_opcode),
        .res_add  (in_res_add),
        .res_sub  (in_res_sub),
        .ovf_add  (in_ovf_add),
        .ovf_sub  (in_ovf_sub),
        .res_and  (in_res_and),
        .res_or   (in_res_or),
        .res_sll  (in_res_sll),
        .res_sra  (in_res_sra),
        .result   (new_entry.result),
        .overflow (new_entry.overflow),
        .ne       (new_entry.ne),
        .lt       (new_entry.lt),
        .illegal  (new_entry.illegal)
    );

`ifdef ALU_RES_ZERO_FLAG_EN
    assign new_entry.zero = (new_entry.result == '0);
`endif

    assign take_in = in_valid & in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= state_next;
            in_ready <= (state_next != ST_FULL);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (take_in) state_next = ST_HALF;
            ST_HALF: begin
                if (take_in && !out_ready)      state_next = ST_FULL;
                else if (!take_in && out_ready) state_next = ST_EMPTY;
            end
            ST_FULL:  if (out_ready) state_next = ST_HALF;
            default:  state_next = ST_EMPTY;
        endcase
    end

    always_comb begin
        load_main = 1'b0;
        load_skid = 1'b0;
        move_skid = 1'b0;
        case (state)
            ST_EMPTY: load_main = take_in;
            ST_HALF: begin
                load_main = take_in & out_ready;
                load_skid = take_in & ~out_ready;
            end
            ST_FULL:  move_skid = out_ready;
            default:  ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main)      main_q <= new_entry;
            else if (move_skid) main_q <= skid_q;
            if (load_skid)      skid_q <= new_entry;
        end
    end

    assign out_valid    = (state != ST_EMPTY);
    assign out_result   = main_q.result;
    assign out_overflow = main_q.overflow;
    assign out_ne       = main_q.ne;
    assign out_lt       = main_q.lt;
    assign out_illegal  = main_q.illegal;
`ifdef ALU_RES_ZERO_FLAG_EN
    assign out_zero     = main_q.zero;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed-vector bench for alu_result_stage; inputs change and outputs are sampled on the falling edge.
module tb_alu_result_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_opcode = '0;
    logic [31:0] in_res_add = '0, in_res_sub = '0, in_res_and = '0;
    logic [31:0] in_res_or = '0, in_res_sll = '0, in_res_sra = '0;
    logic        in_ovf_add = 1'b0, in_ovf_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_overflow, out_ne, out_lt, out_illegal;
`ifdef ALU_RES_ZERO_FLAG_EN
    logic        out_zero;
`endif

    int checks = 0;
    int passed = 0;

    always #5 clock = ~clock;

    alu_result_stage dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_res_add   (in_res_add),
        .in_res_sub   (in_res_sub),
        .in_ovf_add   (in_ovf_add),
        .in_ovf_sub   (in_ovf_sub),
        .in_res_and   (in_res_and),
        .in_res_or    (in_res_or),
        .in_res_sll   (in_res_sll),
        .in_res_sra   (in_res_sra),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_overflow (out_overflow),
        .out_ne       (out_ne),
        .out_lt       (out_lt),
`ifdef ALU_RES_ZERO_FLAG_EN
        .out_zero     (out_zero),
`endif
        .out_illegal  (out_illegal)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Zero every result bus, then put v on the bus the opcode selects.
    task automatic drive(input logic [4:0] op, input logic [31:0] v);
        in_opcode  = op;
        in_res_add = '0; in_res_sub = '0; in_res_and = '0;
        in_res_or  = '0; in_res_sll = '0; in_res_sra = '0;
        in_ovf_add = 1'b0; in_ovf_sub = 1'b0;
        case (op)
            5'd0: in_res_add = v;
            5'd1: in_res_sub = v;
            5'd2: in_res_and = v;
            5'd3: in_res_or  = v;
            5'd4: in_res_sll = v;
            5'd5: in_res_sra = v;
            default: ;
        endcase
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        step();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_result", out_result, 32'd0);
        check("rst_flags", {28'd0, out_overflow, out_ne, out_lt, out_illegal}, 32'd0);
        reset = 1'b0;
        step();

        // OR pass-through
        drive(5'd3, 32'hF0F0_0F0F);
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("or_valid", {31'd0, out_valid}, 32'd1);
        check("or_result", out_result, 32'hF0F0_0F0F);
        check("or_flags", {28'd0, out_overflow, out_ne, out_lt, out_illegal}, 32'd0);
        step();
        check("or_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: ADD, AND, OR with out_ready low
        out_ready = 1'b0;
        drive(5'd0, 32'h11); in_ovf_add = 1'b1; in_valid = 1'b1;
        step();
        check("bp_rdy_after1", {31'd0, in_ready}, 32'd1);
        drive(5'd2, 32'h22); in_ovf_add = 1'b1;
        step();
        check("bp_rdy_after2", {31'd0, in_ready}, 32'd0);
        check("bp_head", out_result, 32'h11);
        check("bp_head_ovf", {31'd0, out_overflow}, 32'd1);
        drive(5'd3, 32'h33);
        step();
        check("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
        check("bp_hold_result", out_result, 32'h11);
        out_ready = 1'b1;
        step();
        check("bp_second", out_result, 32'h22);
        check("bp_second_ovf", {31'd0, out_overflow}, 32'd0);
        check("bp_rdy_back", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_third", out_result, 32'h33);
        check("bp_third_valid", {31'd0, out_valid}, 32'd1);
        step();
        check("bp_empty", {31'd0, out_valid}, 32'd0);

        // Streaming 16 ADDs at full rate
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                check("st_valid", {31'd0, out_valid}, 32'd1);
                check("st_result", out_result, 32'(100 + i - 1));
            end
            if (i < 16) begin
                check("st_in_ready", {31'd0, in_ready}, 32'd1);
                drive(5'd0, 32'(100 + i));
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            step();
        end
        check("st_empty", {31'd0, out_valid}, 32'd0);

        // Flags
        drive(5'd1, 32'h8000_0000); in_ovf_sub = 1'b1; in_valid = 1'b1;
        step();
        check("sub_ovf_result", out_result, 32'h8000_0000);
        check("sub_ovf_flags", {29'd0, out_overflow, out_ne, out_lt}, 32'b110);
        drive(5'd1, 32'h0);
        step();
        check("sub_eq_flags", {29'd0, out_overflow, out_ne, out_lt}, 32'b000);
        drive(5'd1, 32'hFFFF_FFFF);
        step();
        check("sub_neg_flags", {29'd0, out_overflow, out_ne, out_lt}, 32'b011);
        drive(5'd2, 32'h0000_00FF); in_ovf_add = 1'b1; in_ovf_sub = 1'b1; in_res_sub = 32'h5;
        step();
        check("and_mask_result", out_result, 32'h0000_00FF);
        check("and_mask_flags", {29'd0, out_overflow, out_ne, out_lt}, 32'b011);
        drive(5'd4, 32'h0000_0100);
        step();
        check("sll_result", out_result, 32'h0000_0100);
        drive(5'd5, 32'hFFFF_FFF0);
        step();
        check("sra_result", out_result, 32'hFFFF_FFF0);

        // Illegal opcode
        drive(5'd7, 32'h0); in_res_add = 32'hDEAD_BEEF; in_res_or = 32'h1234_5678;
        step();
        in_valid = 1'b0;
        check("ill_valid", {31'd0, out_valid}, 32'd1);
        check("ill_result", out_result, 32'd0);
        check("ill_flag", {31'd0, out_illegal}, 32'd1);
`ifdef ALU_RES_ZERO_FLAG_EN
        check("ill_zero", {31'd0, out_zero}, 32'd1);
`endif
        step();
        check("ill_drained", {31'd0, out_valid}, 32'd0);

        // Reset while FULL
        out_ready = 1'b0;
        drive(5'd0, 32'hAA); in_valid = 1'b1;
        step();
        drive(5'd0, 32'hBB);
        step();
        in_valid = 1'b0;
        check("rf_full", {31'd0, in_ready}, 32'd0);
        #1 reset = 1'b1;
        #1;
        check("rf_out_valid", {31'd0, out_valid}, 32'd0);
        check("rf_in_ready", {31'd0, in_ready}, 32'd1);
        check("rf_result", out_result, 32'd0);
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        check("rf_no_stale1", {31'd0, out_valid}, 32'd0);
        step();
        check("rf_no_stale2", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
